// File: rtl/alarm_edit_controller.sv
// Alarm-setting sequencer: SET hold enters/commits edit mode, short SET toggles field,
// INC bumps the selected shadow field, inactivity aborts the edit.
module alarm_edit_controller #(
  parameter int unsigned HOLD_S    = 5,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_btn,
  input  logic       inc_btn,
  output logic [4:0] alarm_hh,
  output logic [5:0] alarm_mm,
  output logic [4:0] disp_hh,
  output logic [5:0] disp_mm,
  output logic       edit_mode,
  output logic       field,
  output logic [2:0] hold_left,
  output logic       saved,
  output logic       timed_out
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] HOLD_ENTER = 3'd1;
  localparam logic [2:0] EDIT_HH    = 3'd2;
  localparam logic [2:0] EDIT_MM    = 3'd3;
  localparam logic [2:0] HOLD_SAVE  = 3'd4;

  localparam logic [2:0] HOLD_INIT = 3'(HOLD_S);
  localparam logic [3:0] TIMEOUT_V = 4'(TIMEOUT_S);

  logic [2:0] state, state_n;
  logic       set_q;
  logic       set_rise;
  logic [3:0] idle_cnt, idle_n;
  logic [4:0] sh_hh, sh_hh_n;
  logic [5:0] sh_mm, sh_mm_n;
  logic [2:0] hold_n;
  logic [4:0] al_hh_n, disp_hh_n;
  logic [5:0] al_mm_n, disp_mm_n;
  logic       field_n, saved_n, timed_out_n, edit_n;

  assign set_rise = set_btn & ~set_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      set_q     <= 1'b0;
      idle_cnt  <= 4'd0;
      sh_hh     <= 5'd0;
      sh_mm     <= 6'd0;
      alarm_hh  <= 5'd0;
      alarm_mm  <= 6'd0;
      disp_hh   <= 5'd0;
      disp_mm   <= 6'd0;
      edit_mode <= 1'b0;
      field     <= 1'b0;
      hold_left <= HOLD_INIT;
      saved     <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_n;
      set_q     <= set_btn;
      idle_cnt  <= idle_n;
      sh_hh     <= sh_hh_n;
      sh_mm     <= sh_mm_n;
      alarm_hh  <= al_hh_n;
      alarm_mm  <= al_mm_n;
      disp_hh   <= disp_hh_n;
      disp_mm   <= disp_mm_n;
      edit_mode <= edit_n;
      field     <= field_n;
      hold_left <= hold_n;
      saved     <= saved_n;
      timed_out <= timed_out_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    idle_n      = idle_cnt;
    sh_hh_n     = sh_hh;
    sh_mm_n     = sh_mm;
    al_hh_n     = alarm_hh;
    al_mm_n     = alarm_mm;
    hold_n      = hold_left;
    field_n     = field;
    saved_n     = 1'b0;
    timed_out_n = 1'b0;
    edit_n      = 1'b0;
    disp_hh_n   = alarm_hh;
    disp_mm_n   = alarm_mm;

    case (state)
      IDLE: begin
        if (set_rise) begin
          state_n = HOLD_ENTER;
          hold_n  = HOLD_INIT;
        end
      end
      HOLD_ENTER: begin
        if (!set_btn) begin
          state_n = IDLE;
          hold_n  = HOLD_INIT;
        end else if (tick) begin
          if (hold_left == 3'd1) begin
            state_n = EDIT_HH;
            sh_hh_n = alarm_hh;
            sh_mm_n = alarm_mm;
            field_n = 1'b0;
            idle_n  = 4'd0;
            hold_n  = HOLD_INIT;
          end else begin
            hold_n = hold_left - 3'd1;
          end
        end
      end
      EDIT_HH, EDIT_MM: begin
        if (inc_btn) begin
          idle_n = 4'd0;
          if (state == EDIT_HH) sh_hh_n = (sh_hh == 5'd23) ? 5'd0 : sh_hh + 5'd1;
          else                  sh_mm_n = (sh_mm == 6'd59) ? 6'd0 : sh_mm + 6'd1;
        end
        if (set_rise) begin
          state_n = HOLD_SAVE;
          hold_n  = HOLD_INIT;
          idle_n  = 4'd0;
        end else if (tick && !inc_btn) begin
          // Quiet tick: advance inactivity count, abort when it reaches the limit
          if (idle_cnt + 4'd1 == TIMEOUT_V) begin
            state_n     = IDLE;
            idle_n      = 4'd0;
            timed_out_n = 1'b1;
          end else begin
            idle_n = idle_cnt + 4'd1;
          end
        end
      end
      HOLD_SAVE: begin
        idle_n = 4'd0;
        if (!set_btn) begin
          state_n = field ? EDIT_HH : EDIT_MM;
          field_n = ~field;
          hold_n  = HOLD_INIT;
        end else if (tick) begin
          if (hold_left == 3'd1) begin
            state_n = IDLE;
            al_hh_n = sh_hh;
            al_mm_n = sh_mm;
            saved_n = 1'b1;
            hold_n  = HOLD_INIT;
          end else begin
            hold_n = hold_left - 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        hold_n  = HOLD_INIT;
      end
    endcase

    edit_n    = (state_n == EDIT_HH) || (state_n == EDIT_MM) || (state_n == HOLD_SAVE);
    disp_hh_n = edit_n ? sh_hh_n : al_hh_n;
    disp_mm_n = edit_n ? sh_mm_n : al_mm_n;
  end

endmodule

// File: doc/alarm_edit_controller.md
Name: alarm_edit_controller

Overview:
- Sequences the user-facing alarm-setting flow of the alarm clock from a single SET button and an INC button.
- Holding SET for HOLD_S seconds enters edit mode. In edit mode, a short SET press toggles between the hours and minutes fields, and holding SET for HOLD_S seconds commits the edits.
- Inactivity during editing times out and discards the edits.
- Sits between the debounced button inputs and the alarm compare/display logic. It owns the committed alarm time registers.

Parameters:
- HOLD_S, 5, hold duration in 1 Hz ticks needed to enter or save (1..7).
- TIMEOUT_S, 10, edit inactivity timeout in ticks (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse at 1 Hz (enable, not a clock)
- set_btn  in  1  debounced SET level, 1 = pressed
- inc_btn  in  1  debounced one-cycle INC press pulse
- alarm_hh  out  5  committed alarm hours, 0..23
- alarm_mm  out  6  committed alarm minutes, 0..59
- disp_hh  out  5  hours to display: shadow while editing, else committed
- disp_mm  out  6  minutes to display: shadow while editing, else committed
- edit_mode  out  1  high in EDIT_HH, EDIT_MM and HOLD_SAVE
- field  out  1  0 = hours selected, 1 = minutes selected
- hold_left  out  3  ticks remaining in the current hold; HOLD_S when not holding
- saved  out  1  one-cycle pulse on commit
- timed_out  out  1  one-cycle pulse on inactivity abort

Behaviour:
- Reset values, applied on a clk edge with rst=1:
  - State = IDLE.
  - alarm_hh = alarm_mm = 0; shadow registers = 0; field = 0.
  - hold_left = HOLD_S; idle counter = 0.
  - saved = timed_out = edit_mode = 0; set_btn edge register = 0.
  - rst mid-operation aborts everything and discards shadow values.
- Press detection uses a registered rising edge only: set_rise = set_btn & ~set_btn_q. A continuously held SET never re-triggers.
- IDLE:
  - set_rise -> HOLD_ENTER with hold_left = HOLD_S.
  - inc_btn ignored.
- HOLD_ENTER:
  - set_btn = 0 -> IDLE, hold_left reloads to HOLD_S. Release wins over a same-cycle tick.
  - tick with hold_left > 1 -> hold_left decrements.
  - tick with hold_left == 1 -> EDIT_HH in the next cycle. On that transition: shadow := committed, field = 0, idle counter = 0, hold_left = HOLD_S.
- EDIT_HH / EDIT_MM:
  - inc_btn increments the selected shadow field by 1: hours wrap 23->0, minutes wrap 59->0. Inc clears the idle counter.
  - set_rise -> HOLD_SAVE, remembering the current field, hold_left = HOLD_S. A same-cycle inc_btn is still applied.
  - tick with no inc/set activity in that cycle increments the idle counter. When it reaches TIMEOUT_S -> IDLE, shadow discarded, timed_out pulses one cycle.
  - Activity in the same cycle as the timeout tick wins: counter clears, no timeout.
- HOLD_SAVE:
  - inc_btn ignored; idle counter frozen at 0.
  - set_btn = 0 before expiry (short press) -> return to the other edit state (field toggles), hold_left = HOLD_S.
  - tick with hold_left == 1 while held -> commit: alarm_hh/alarm_mm := shadow, saved = 1 for exactly one cycle, state -> IDLE.
  - Still-held SET after commit does not re-enter HOLD_ENTER, because no new rising edge occurs.
- Outputs are all registered. disp_* follows the shadow whenever edit_mode = 1.
- Arithmetic: hold_left is 3 bits and the idle counter is 4 bits. Neither ever underflows or overflows at legal parameter values.

Test Plan:
- Reset, then press SET and hold 5 ticks -> hold_left 5,4,3,2,1, then edit_mode=1, field=0, disp_hh=0, hold_left=5.
- In EDIT_HH with shadow hh=22, send 3 inc_btn pulses -> disp_hh 23,0,1; alarm_hh stays 0.
- In EDIT_HH, SET press released after 2 ticks -> field=1 (EDIT_MM), hold_left back to 5, no saved pulse. Then inc with mm=59 -> disp_mm=0.
- In EDIT_MM with shadow 07:30, hold SET 5 ticks -> saved pulses one cycle, alarm_hh=7, alarm_mm=30, edit_mode=0. Continued holding keeps the state in IDLE.
- In edit mode, no activity for 10 ticks -> timed_out pulse, state IDLE, alarm_* unchanged. An inc on the 10th tick instead prevents the timeout.
- rst asserted in HOLD_SAVE at hold_left=2 -> next cycle state IDLE, alarm_*=0, hold_left=5, no saved pulse.
